// File: rtl/dmem_pipelined.sv
// -----------------------------------------------------------------------------
// dmem_pipelined
//   Pipelined data memory for the 48-bit CPU memory stage. After reset, a
//   hardware sweep writes zero to every word. Requests are accepted with a
//   Req/Ready handshake. Each accepted read returns a response LATENCY cycles
//   later, and responses come back in the order the reads were accepted.
//
// Parameters
//   WIDTH   - data word width; also the width of the address port
//   DEPTH   - number of words (power of two, >= 4)
//   LATENCY - read latency from accept edge to response (1..4)
//
// Optional feature
//   DMEM_OOB_CHECK_EN - when defined, an address with any bit at or above
//                       position AW set is out of bounds. Writes to such an
//                       address are dropped. Reads from it return zero with
//                       RspErr set. Either case sets OobSticky. When the macro
//                       is undefined, the address wraps modulo DEPTH.
//
// Ports
//   CLK       - clock, rising edge
//   Reset     - asynchronous active-high reset
//   Req       - request valid
//   WE        - 1 = write, 0 = read; sampled with Req
//   A         - word address
//   WD        - write data
//   Ready     - a request is accepted this cycle
//   Stall     - ~Ready, to the CPU hazard unit
//   RspValid  - one-cycle read response pulse
//   RD        - read data; holds its last value between responses
//   RspErr    - out-of-bounds flag, aligned with RspValid
//   OobSticky - sticky out-of-bounds indicator, cleared only by Reset
// -----------------------------------------------------------------------------
module dmem_pipelined #(
   parameter int unsigned WIDTH   = 48,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Req,
   input  logic             WE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] WD,
   output logic             Ready,
   output logic             Stall,
   output logic             RspValid,
   output logic [WIDTH-1:0] RD,
   output logic             RspErr,
   output logic             OobSticky
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [0:0] {StClear, StIdle} state_e;

   state_e          state_q, state_d;
   logic            ready_q, ready_d;
   logic [AW-1:0]   clr_addr_q, clr_addr_d;
   logic            oob_sticky_q, oob_sticky_d;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             accept;
   logic             rd_accept;
   logic             oob;
   logic [AW-1:0]    a_idx;
   logic [WIDTH-1:0] rd_data_in;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   logic             pipe_vld_q  [LATENCY];
   logic             pipe_vld_d  [LATENCY];
   logic             pipe_err_q  [LATENCY];
   logic             pipe_err_d  [LATENCY];
   logic [WIDTH-1:0] pipe_data_q [LATENCY];
   logic [WIDTH-1:0] pipe_data_d [LATENCY];

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   assign a_idx = A[AW-1:0];

`ifdef DMEM_OOB_CHECK_EN
   assign oob = |A[WIDTH-1:AW];
`else
   // Upper address bits are deliberately ignored, so the address wraps.
   logic unused_a_hi;
   assign unused_a_hi = ^A[WIDTH-1:AW];
   assign oob         = 1'b0;
`endif

   assign accept    = Req & ready_q;
   assign rd_accept = accept & ~WE;

   // ---------------------------------------------------------------------------
   // Clear-sweep FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      ready_d    = ready_q;
      clr_addr_d = clr_addr_q;
      unique case (state_q)
         StClear: begin
            clr_addr_d = clr_addr_q + 1'b1;
            // The edge that writes the last word also leaves the sweep.
            if (clr_addr_q == {AW{1'b1}}) begin
               state_d = StIdle;
               ready_d = 1'b1;
            end
         end
         StIdle: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = StClear;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q    <= StClear;
         ready_q    <= 1'b0;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Memory array: the sweep owns the write port until the FSM reaches idle
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_addr_q;
      mem_wdata = '0;
      if (state_q == StClear) begin
         mem_we = 1'b1;
      end else if (accept && WE && !oob) begin
         mem_we    = 1'b1;
         mem_waddr = a_idx;
         mem_wdata = WD;
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Only one request is accepted per cycle, so a read never races a write
   // on the same edge. The read sees every write from earlier edges.
   assign rd_data_in = oob ? '0 : mem[a_idx];

   // ---------------------------------------------------------------------------
   // Read response pipeline
   // ---------------------------------------------------------------------------
   always_comb begin
      pipe_vld_d[0]  = rd_accept;
      pipe_err_d[0]  = rd_accept & oob;
      pipe_data_d[0] = rd_accept ? rd_data_in : pipe_data_q[0];
      for (int unsigned i = 1; i < LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_err_d[i]  = pipe_err_q[i-1];
         // Data moves only with a valid read, so the last stage holds RD.
         pipe_data_d[i] = pipe_vld_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            pipe_vld_q[i]  <= 1'b0;
            pipe_err_q[i]  <= 1'b0;
            pipe_data_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            pipe_vld_q[i]  <= pipe_vld_d[i];
            pipe_err_q[i]  <= pipe_err_d[i];
            pipe_data_q[i] <= pipe_data_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky out-of-bounds flag (constant zero when the check is disabled)
   // ---------------------------------------------------------------------------
   assign oob_sticky_d = oob_sticky_q | (accept & oob);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         oob_sticky_q <= 1'b0;
      end else begin
         oob_sticky_q <= oob_sticky_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign Ready     = ready_q;
   assign Stall     = ~ready_q;
   assign RspValid  = pipe_vld_q[LATENCY-1];
   assign RD        = pipe_data_q[LATENCY-1];
   assign RspErr    = pipe_err_q[LATENCY-1];
   assign OobSticky = oob_sticky_q;

endmodule

// File: tb/tb_dmem_pipelined.sv
// -----------------------------------------------------------------------------
// tb_dmem_pipelined
//   Self-checking bench for dmem_pipelined with WIDTH=48, DEPTH=16, LATENCY=2.
//   A per-cycle vector table drives the main traffic. Hand-written sequences
//   cover reset, the clear sweep and reset with reads in flight. Expected
//   values follow DMEM_OOB_CHECK_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_dmem_pipelined;

   localparam int unsigned W   = 48;
   localparam int unsigned DEP = 16;
   localparam int unsigned LAT = 2;

`ifdef DMEM_OOB_CHECK_EN
   localparam bit OOB = 1'b1;
`else
   localparam bit OOB = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         req;
   logic         we;
   logic [W-1:0] a;
   logic [W-1:0] wd;
   logic         ready;
   logic         stall;
   logic         rsp_valid;
   logic [W-1:0] rd;
   logic         rsp_err;
   logic         oob_sticky;

   int n_pass;
   int n_total;

   dmem_pipelined #(
      .WIDTH  (W),
      .DEPTH  (DEP),
      .LATENCY(LAT)
   ) dut (
      .CLK      (clk),
      .Reset    (rst),
      .Req      (req),
      .WE       (we),
      .A        (a),
      .WD       (wd),
      .Ready    (ready),
      .Stall    (stall),
      .RspValid (rsp_valid),
      .RD       (rd),
      .RspErr   (rsp_err),
      .OobSticky(oob_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs for one cycle plus the outputs expected just after that edge.
   typedef struct {
      logic         req;
      logic         we;
      logic [W-1:0] a;
      logic [W-1:0] wd;
      logic         exp_vld;
      logic [W-1:0] exp_rd;
      logic         exp_err;
      logic         exp_sticky;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic w, input logic [W-1:0] ad,
                      input logic [W-1:0] d, input logic ev, input logic [W-1:0] erd,
                      input logic ee, input logic es);
      vec_t v;
      v.req = r; v.we = w; v.a = ad; v.wd = d;
      v.exp_vld = ev; v.exp_rd = erd; v.exp_err = ee; v.exp_sticky = es;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] h;
      logic [W-1:0] oob_rd;
      logic [W-1:0] oob_wr_rd;
      h         = 48'h1234_5678_9ABC;
      oob_rd    = OOB ? 48'h0  : 48'h44;
      oob_wr_rd = OOB ? 48'h44 : 48'h55;
      n_pass    = 0;
      n_total   = 0;

      // -- Vector table: req we addr wd | vld rd err sticky -----------------
      add(1, 0, 5,  0,    0, 0,    0, 0);  // read 5 (freshly cleared)
      add(0, 0, 0,  0,    1, 0,    0, 0);
      add(1, 0, 2,  0,    0, 0,    0, 0);  // read 2: write held during sweep must be lost
      add(1, 1, 3,  h,    1, 0,    0, 0);
      add(1, 0, 3,  0,    0, 0,    0, 0);
      add(0, 0, 0,  0,    1, h,    0, 0);
      add(0, 0, 0,  0,    0, h,    0, 0);  // RD holds
      add(1, 1, 0,  10,   0, h,    0, 0);
      add(1, 1, 1,  11,   0, h,    0, 0);
      add(1, 1, 2,  12,   0, h,    0, 0);
      add(1, 1, 3,  13,   0, h,    0, 0);
      add(1, 0, 0,  0,    0, h,    0, 0);  // four back-to-back reads
      add(1, 0, 1,  0,    1, 10,   0, 0);
      add(1, 0, 2,  0,    1, 11,   0, 0);
      add(1, 0, 3,  0,    1, 12,   0, 0);
      add(0, 0, 0,  0,    1, 13,   0, 0);
      add(0, 0, 0,  0,    0, 13,   0, 0);
      add(1, 1, 7,  'hAA, 0, 13,   0, 0);
      add(1, 0, 7,  0,    0, 13,   0, 0);  // read / write / read same address
      add(1, 1, 7,  'hBB, 1, 'hAA, 0, 0);
      add(1, 0, 7,  0,    0, 'hAA, 0, 0);
      add(0, 0, 0,  0,    1, 'hBB, 0, 0);
      add(1, 1, 4,  'h44, 0, 'hBB, 0, 0);
      add(1, 0, 20, 0,    0, 'hBB, 0, OOB);  // out-of-bounds read
      add(0, 0, 0,  0,    1, oob_rd, OOB, OOB);
      add(1, 1, 36, 'h55, 0, oob_rd, 0, OOB);  // out-of-bounds write
      add(1, 0, 4,  0,    0, oob_rd, 0, OOB);
      add(0, 0, 0,  0,    1, oob_wr_rd, 0, OOB);

      // -- Reset values ------------------------------------------------------
      rst = 1'b1; req = 1'b0; we = 1'b0; a = '0; wd = '0;
      tick();
      tick();
      check("reset ready",    64'(ready),      64'h0);
      check("reset stall",    64'(stall),      64'h1);
      check("reset rspvalid", 64'(rsp_valid),  64'h0);
      check("reset rd",       64'(rd),         64'h0);
      check("reset rsperr",   64'(rsp_err),    64'h0);
      check("reset sticky",   64'(oob_sticky), 64'h0);

      // -- Clear sweep, with a write held against Ready=0 --------------------
      rst = 1'b0;
      req = 1'b1; we = 1'b1; a = 2; wd = 48'hDEAD;
      for (int c = 1; c <= int'(DEP); c++) begin
         check($sformatf("sweep c%0d ready", c), 64'(ready),     64'h0);
         check($sformatf("sweep c%0d stall", c), 64'(stall),     64'h1);
         check($sformatf("sweep c%0d vld",   c), 64'(rsp_valid), 64'h0);
         tick();
      end
      check("sweep done ready", 64'(ready), 64'h1);
      check("sweep done stall", 64'(stall), 64'h0);

      // -- Table-driven traffic ----------------------------------------------
      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req; we = vecs[i].we; a = vecs[i].a; wd = vecs[i].wd;
         tick();
         check($sformatf("vec%0d vld",    i), 64'(rsp_valid),  64'(vecs[i].exp_vld));
         check($sformatf("vec%0d rd",     i), 64'(rd),         64'(vecs[i].exp_rd));
         check($sformatf("vec%0d err",    i), 64'(rsp_err),    64'(vecs[i].exp_err));
         check($sformatf("vec%0d sticky", i), 64'(oob_sticky), 64'(vecs[i].exp_sticky));
         check($sformatf("vec%0d ready",  i), 64'(ready),      64'h1);
      end
      req = 1'b0;

      // -- Reset with two reads in flight ------------------------------------
      req = 1'b1; we = 1'b0; a = 3;
      tick();
      a = 1;
      tick();
      req = 1'b0;
      check("inflight first rsp vld", 64'(rsp_valid), 64'h1);
      check("inflight first rsp rd",  64'(rd),        64'd13);
      rst = 1'b1;
      #1;
      check("midreset rspvalid", 64'(rsp_valid),  64'h0);
      check("midreset ready",    64'(ready),      64'h0);
      check("midreset stall",    64'(stall),      64'h1);
      check("midreset rd",       64'(rd),         64'h0);
      check("midreset sticky",   64'(oob_sticky), 64'h0);
      tick();
      tick();
      rst = 1'b0;
      for (int c = 1; c <= int'(DEP); c++) begin
         check($sformatf("resweep c%0d ready", c), 64'(ready),     64'h0);
         check($sformatf("resweep c%0d vld",   c), 64'(rsp_valid), 64'h0);
         tick();
      end
      check("resweep done ready", 64'(ready), 64'h1);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("post-reset idle%0d vld", c), 64'(rsp_valid), 64'h0);
         tick();
      end

      // Addr 3 held 13 before the reset; the new sweep must have cleared it.
      req = 1'b1; we = 1'b0; a = 3;
      tick();
      req = 1'b0;
      check("post-reset read early vld", 64'(rsp_valid), 64'h0);
      tick();
      check("post-reset read vld", 64'(rsp_valid), 64'h1);
      check("post-reset read rd",  64'(rd),        64'h0);
      tick();
      check("post-reset read pulse", 64'(rsp_valid), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_pipelined.md
# dmem_pipelined

Parametrised, pipelined data memory for the 48-bit pipelined CPU and its successors. It replaces the single-cycle `dmem` with configurable width, depth and read latency. It uses a request/ready handshake so the CPU memory stage can stall, and a hardware clear sweep after reset. It sits between the CPU memory-stage port (`ALUOutM`/`WriteDataM`/`MemWriteM`) and the writeback stage.

## Interface
- `WIDTH`, 48, data word width in bits; also the width of the address port.
- `DEPTH`, 256, number of words; must be a power of two ≥ 4; `AW = $clog2(DEPTH)`.
- `LATENCY`, 2, read latency in cycles from accept to response; legal range 1..4.
- `CLK` input 1: single clock, rising-edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Req` input 1: request valid.
- `WE` input 1: 1 = write, 0 = read; sampled with `Req`.
- `A` input WIDTH: word address (not byte address).
- `WD` input WIDTH: write data.
- `Ready` output 1: the block accepts a request this cycle.
- `Stall` output 1: equals `~Ready`; feeds the CPU hazard unit.
- `RspValid` output 1: read response valid, one-cycle pulse per read.
- `RD` output WIDTH: read data, valid when `RspValid`=1.
- `RspErr` output 1: out-of-bounds flag aligned with `RspValid`.
- `OobSticky` output 1: sticky out-of-bounds indicator.

## Operation
- **Accept rule:** a request is accepted on a rising edge where `Req && Ready`. At most one request per cycle. The block is fully pipelined, so there are no bubbles between accepts.
- **FSM states:** `CLEAR` and `IDLE`.
  - `CLEAR`:
    - `Ready`=0.
    - A counter `clr_addr` writes zero to word `clr_addr` each cycle, then increments.
    - After the edge that writes word `DEPTH-1`, the FSM goes to `IDLE`.
  - `IDLE`: `Ready`=1; the FSM stays here until `Reset`.
- **Write:** memory is updated at the accept edge. Writes produce no response.
- **Read:**
  - The array is sampled at the accept edge.
  - Data, the valid bit and the error bit travel a `LATENCY`-deep shift pipeline.
  - Responses emerge strictly in accept order.
- **Ordering:** a read accepted at edge t returns data reflecting every write accepted at edges < t.
- **RD hold:** `RD` holds its last response value when `RspValid`=0.
- **Address range:** only `A[AW-1:0]` indexes the array. The upper bits are handled as set out in Configuration.

## Timing
- **Reset values** (immediately on assertion, no clock needed):
  - `Ready`=0, `Stall`=1, `RspValid`=0, `RD`=0, `RspErr`=0, `OobSticky`=0.
  - FSM=`CLEAR`, `clr_addr`=0, read-pipeline valids cleared.
- **Clear sweep:** after `Reset` deasserts, the sweep takes exactly `DEPTH` edges. `Ready` rises on the cycle after the last clear write. With `DEPTH`=16, `Ready` is first high in cycle 17.
- **Read latency:** for a read accepted at edge t, `RspValid`=1 and `RD` are valid in the cycle following edge t+`LATENCY`-1. With `LATENCY`=1 this is the cycle right after accept.
- **Throughput:** N back-to-back reads give N consecutive `RspValid` cycles.
- **Mixed traffic:** a read, then a write to the same address, then a read again returns the old value, then the new value.
- **Reset mid-operation:**
  - In-flight reads are discarded; no stale `RspValid` appears after reset.
  - A sweep in progress restarts from address 0.
- **Requests while not ready:** a `Req` while `Ready`=0 is ignored and has no side effects. The requester must hold it.

## Configuration
- `DMEM_OOB_CHECK_EN` defined: an access is out-of-bounds when `A >= DEPTH` (any upper bit set).
  - An OOB write is suppressed and sets `OobSticky`.
  - An OOB read returns `RD`=0 with `RspErr`=1 on its response cycle and sets `OobSticky`.
  - `OobSticky` clears only on `Reset`.
- `DMEM_OOB_CHECK_EN` undefined: the upper address bits are ignored, so the address wraps modulo `DEPTH`. `RspErr` and `OobSticky` are tied to 0.

## Test plan
- **Reset release** (`DEPTH`=16, `LATENCY`=2): `Ready`=0 and `Stall`=1 for 16 cycles, `Ready`=1 in cycle 17. Then read addr 5 → `RD`=0, `RspValid` 2 cycles after accept.
- **Write then read:** write `0x123456789ABC` to addr 3, read addr 3 on the next cycle → `RspValid` pulse with `RD`=`0x123456789ABC` exactly `LATENCY` cycles after the read accept.
- **Back-to-back reads:** write addr 0..3 with values 10..13, then issue four consecutive reads 0..3 → `RspValid` high 4 consecutive cycles, `RD` = 10, 11, 12, 13 in order.
- **Read/write/read, same address:** addr 7 holds `0xAA`. Read 7, write `0xBB` to 7, read 7 → responses `0xAA`, then `0xBB`.
- **Out-of-bounds read of addr 20** (`DEPTH`=16):
  - With `DMEM_OOB_CHECK_EN`: `RD`=0, `RspErr`=1, `OobSticky`=1 until `Reset`.
  - Without it: returns the contents of addr 4, `RspErr`=0.
- **Reset with reads in flight:** assert `Reset` with 2 reads in flight → `RspValid`=0 and `Ready`=0 immediately. After release, no response appears until new reads are issued after the sweep.
